ahbl_cmd_arbiter: RTL and testbench

AHBL_CMD_ARBITER -- requirements
Module: ahbl_cmd_arbiter

---
 rtl/ahbl_arb_pkg.sv | 41 ++++
 rtl/ahbl_rr_arb2.sv | 65 ++++++
 rtl/ahbl_cmd_arbiter.sv | 157 +++++++++++++++
 tb/tb_ahbl_cmd_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_arb_pkg.sv
// ---------------------------------------------------------------------------
// ahbl_arb_pkg
// Shared definitions for the two-requester AHB-Lite command arbiter:
//   - HTRANS / HBURST / HPROT encodings driven on the bus
//   - FSM state type and state constants
//   - latched command record and the command legality check
// ---------------------------------------------------------------------------
package ahbl_arb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_ADDR = 2'd1;
   localparam state_t ST_DATA = 2'd2;
   localparam state_t ST_RESP = 2'd3;

   typedef struct packed {
      logic        write;
      logic        lock;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   // Byte, halfword and word only; halfword/word must be naturally aligned.
   function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lsb);
      logic ok;
      case (size)
         3'b000:  ok = 1'b1;
         3'b001:  ok = ~addr_lsb[0];
         3'b010:  ok = (addr_lsb == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ahbl_rr_arb2.sv
// ---------------------------------------------------------------------------
// ahbl_rr_arb2
// Two-way grant selection with optional round-robin and bus-lock holding.
//   clk, rst   : clock, synchronous active-high reset
//   enable     : owner FSM can accept a command this cycle
//   req        : per-requester command valid
//   lock_req   : per-requester lock bit of the offered command
//   grant      : one-hot grant (zero when nothing is eligible)
//   grant_idx  : index of the granted requester (0 when no grant)
// ---------------------------------------------------------------------------
module ahbl_rr_arb2
   import ahbl_arb_pkg::*;
#(
   parameter bit RR = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] req,
   input  logic [1:0] lock_req,
   output logic [1:0] grant,
   output logic       grant_idx
);

   logic       rr_prio;      // requester that wins a tie next time
   logic       lock_active;
   logic       lock_owner;
   logic [1:0] eligible;

   always_comb begin
      // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
      eligible  = req;
      grant     = 2'b00;
      grant_idx = 1'b0;
      if (lock_active) begin
         eligible = lock_owner ? (req & 2'b10) : (req & 2'b01);
      end
      if (enable) begin
         case (eligible)
            2'b01: grant_idx = 1'b0;
            2'b10: grant_idx = 1'b1;
            2'b11: grant_idx = RR ? rr_prio : 1'b0;
            default: grant_idx = 1'b0;
         endcase
         if (eligible != 2'b00) begin
            grant = grant_idx ? 2'b10 : 2'b01;
         end
      end
   end

   // A locked grant is released by the owner's next accepted command without lock.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
      if (rst) begin
         rr_prio     <= 1'b0;
         lock_active <= 1'b0;
         lock_owner  <= 1'b0;
      end else if (grant != 2'b00) begin
         rr_prio     <= ~grant_idx;
         lock_active <= lock_req[grant_idx];
         lock_owner  <= grant_idx;
      end
   end

endmodule

// File: rtl/ahbl_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// ahbl_cmd_arbiter
// Arbitrates two command requesters onto one AHB-Lite master port, runs a
// single non-pipelined transfer per command and returns a one-cycle response.
// Parameters:
//   TIMEOUT_CYCLES : consecutive HREADY=0 data-phase cycles before the TIMEOUT
//                    flag sets (0 disables); not named TIMEOUT because that
//                    identifier is the flag output
//   RR             : 1 = round-robin, 0 = fixed priority (requester 0 first)
// Ports:
//   HCLK, HRESET                 : clock, synchronous active-high reset
//   CMD_VALID/READY/WRITE/LOCK   : per-requester command handshake and flags
//   CMD_SIZE/ADDR/WDATA          : packed per-requester fields (req 1 upper)
//   RSP_VALID/RDATA/ERR          : one-cycle response to the owning requester
//   H*                           : AHB-Lite master interface
//   BUSY                         : FSM not idle
//   TIMEOUT                      : sticky wait-state timeout flag
// ---------------------------------------------------------------------------
module ahbl_cmd_arbiter
   import ahbl_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter bit          RR             = 1'b1
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [1:0]  CMD_VALID,
   output logic [1:0]  CMD_READY,
   input  logic [1:0]  CMD_WRITE,
   input  logic [1:0]  CMD_LOCK,
   input  logic [5:0]  CMD_SIZE,
   input  logic [63:0] CMD_ADDR,
   input  logic [63:0] CMD_WDATA,
   output logic [1:0]  RSP_VALID,
   output logic [31:0] RSP_RDATA,
   output logic        RSP_ERR,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   output logic        BUSY,
   output logic        TIMEOUT
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_t         state, state_nxt;
   cmd_t           cmd_q, sel_cmd;
   logic           owner_q;
   logic [31:0]    hwdata_q, rsp_rdata_q;
   logic           rsp_err_q, timeout_q;
   logic [CW-1:0]  wait_cnt;
   logic [1:0]     grant;
   logic           grant_idx, accept, sel_legal;

   ahbl_rr_arb2 #(.RR(RR)) u_arb (
      .clk       (HCLK),
      .rst       (HRESET),
      .enable    (state == ST_IDLE && !HRESET),
      .req       (CMD_VALID),
      .lock_req  (CMD_LOCK),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign accept = (grant != 2'b00);

   always_comb begin
      sel_cmd.write = CMD_WRITE[grant_idx];
      sel_cmd.lock  = CMD_LOCK[grant_idx];
      sel_cmd.size  = grant_idx ? CMD_SIZE[5:3]    : CMD_SIZE[2:0];
      sel_cmd.addr  = grant_idx ? CMD_ADDR[63:32]  : CMD_ADDR[31:0];
      sel_cmd.wdata = grant_idx ? CMD_WDATA[63:32] : CMD_WDATA[31:0];
      sel_legal     = cmd_legal(sel_cmd.size, sel_cmd.addr[1:0]);
   end

   // Illegal commands skip the bus entirely and answer with an error.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = sel_legal ? ST_ADDR : ST_RESP;
         ST_ADDR: if (HREADY) state_nxt = ST_DATA;
         ST_DATA: if (HREADY) state_nxt = ST_RESP;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state       <= ST_IDLE;
         cmd_q       <= '0;
         owner_q     <= 1'b0;
         hwdata_q    <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         wait_cnt    <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state <= state_nxt;

         if (accept) begin
            cmd_q   <= sel_cmd;
            owner_q <= grant_idx;
            if (!sel_legal) begin
               rsp_rdata_q <= '0;
               rsp_err_q   <= 1'b1;
            end
         end

         // Write data follows the address phase into the data phase and is held afterwards.
         if (state == ST_ADDR && HREADY) begin
            hwdata_q <= cmd_q.wdata;
         end

         // HRESP is only meaningful on the completing (HREADY=1) cycle.
         if (state == ST_DATA && HREADY) begin
            rsp_rdata_q <= cmd_q.write ? '0 : HRDATA;
            rsp_err_q   <= HRESP;
         end

         // Saturating wait counter; the flag sets on the edge that reaches the limit.
         if (state == ST_DATA && !HREADY) begin
            if (wait_cnt != CW'(TIMEOUT_CYCLES)) begin
               wait_cnt <= wait_cnt + 1'b1;
            end
            if (TIMEOUT_CYCLES != 0 && wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               timeout_q <= 1'b1;
            end
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   assign CMD_READY = grant;
   assign RSP_VALID = (state == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign RSP_RDATA = rsp_rdata_q;
   assign RSP_ERR   = rsp_err_q;
   assign HADDR     = cmd_q.addr;
   assign HWRITE    = cmd_q.write;
   assign HSIZE     = cmd_q.size;
   assign HTRANS    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HMASTLOCK = (state == ST_ADDR) && cmd_q.lock;
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = HPROT_DEFAULT;
   assign HWDATA    = hwdata_q;
   assign BUSY      = (state != ST_IDLE);
   assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_ahbl_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahbl_cmd_arbiter
// Directed and randomized stimulus for ahbl_cmd_arbiter. A transaction-level
// model (grant winner, lock owner, legality, timeout) predicts every response.
// A second instance with fixed priority runs alongside for the priority checks.
// ---------------------------------------------------------------------------
module tb_ahbl_cmd_arbiter;

   localparam int unsigned TO = 4;

   typedef struct {
      logic        write;
      logic        lock;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } tcmd_t;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [1:0]  CMD_VALID, CMD_WRITE, CMD_LOCK;
   logic [5:0]  CMD_SIZE;
   logic [63:0] CMD_ADDR, CMD_WDATA;
   logic [31:0] HRDATA;
   logic        HREADY, HRESP;

   logic [1:0]  CMD_READY, RSP_VALID, HTRANS;
   logic [31:0] RSP_RDATA, HADDR, HWDATA;
   logic        RSP_ERR, HWRITE, HMASTLOCK, BUSY, TIMEOUT;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;

   logic [1:0]  fp_CMD_READY, fp_RSP_VALID, fp_HTRANS;
   logic [31:0] fp_RSP_RDATA, fp_HADDR, fp_HWDATA;
   logic        fp_RSP_ERR, fp_HWRITE, fp_HMASTLOCK, fp_BUSY, fp_TIMEOUT;
   logic [2:0]  fp_HSIZE, fp_HBURST;
   logic [3:0]  fp_HPROT;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   bit m_prio;         // requester favoured on a tie (round-robin)
   bit m_lock_act;
   bit m_lock_own;
   bit m_to;
   bit chk_fp;
   int grant_log[$];

   always #5 HCLK = ~HCLK;

   ahbl_cmd_arbiter #(.TIMEOUT_CYCLES(TO), .RR(1'b1)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
      .CMD_LOCK(CMD_LOCK), .CMD_SIZE(CMD_SIZE), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
      .BUSY(BUSY), .TIMEOUT(TIMEOUT)
   );

   ahbl_cmd_arbiter #(.TIMEOUT_CYCLES(TO), .RR(1'b0)) dut_fp (
      .HCLK(HCLK), .HRESET(HRESET),
      .CMD_VALID(CMD_VALID), .CMD_READY(fp_CMD_READY), .CMD_WRITE(CMD_WRITE),
      .CMD_LOCK(CMD_LOCK), .CMD_SIZE(CMD_SIZE), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
      .RSP_VALID(fp_RSP_VALID), .RSP_RDATA(fp_RSP_RDATA), .RSP_ERR(fp_RSP_ERR),
      .HADDR(fp_HADDR), .HTRANS(fp_HTRANS), .HWRITE(fp_HWRITE), .HSIZE(fp_HSIZE),
      .HBURST(fp_HBURST), .HPROT(fp_HPROT), .HMASTLOCK(fp_HMASTLOCK), .HWDATA(fp_HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
      .BUSY(fp_BUSY), .TIMEOUT(fp_TIMEOUT)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   function automatic bit legal(input tcmd_t c);
      return (c.size <= 3'd2) && ((c.addr % (32'd1 << c.size)) == 32'd0);
   endfunction

   // Winner index, or -1 when no requester is eligible.
   function automatic int pick(input logic [1:0] vld);
      logic [1:0] elig = vld;
      if (m_lock_act) elig = m_lock_own ? (vld & 2'b10) : (vld & 2'b01);
      if (elig == 2'b00) return -1;
      if (elig == 2'b01) return 0;
      if (elig == 2'b10) return 1;
      return m_prio ? 1 : 0;
   endfunction

   function automatic tcmd_t mk(input bit wr, input bit lk, input logic [2:0] sz,
                                input logic [31:0] a, input logic [31:0] wd);
      tcmd_t c;
      c.write = wr; c.lock = lk; c.size = sz; c.addr = a; c.wdata = wd;
      return c;
   endfunction

   function automatic tcmd_t rand_cmd();
      tcmd_t c;
      logic [31:0] r;
      r       = $urandom;
      c.write = r[0];
      c.lock  = ($urandom_range(0, 3) == 0);
      c.size  = 3'($urandom_range(0, 3));
      c.addr  = $urandom;
      if ($urandom_range(0, 2) != 0) c.addr = c.addr & ~((32'd1 << c.size) - 32'd1);
      c.wdata = $urandom;
      return c;
   endfunction

   task automatic drive_cmds(input logic [1:0] vld, input tcmd_t c0, input tcmd_t c1);
      CMD_VALID = vld;
      CMD_WRITE = {c1.write, c0.write};
      CMD_LOCK  = {c1.lock, c0.lock};
      CMD_SIZE  = {c1.size, c0.size};
      CMD_ADDR  = {c1.addr, c0.addr};
      CMD_WDATA = {c1.wdata, c0.wdata};
   endtask

   task automatic model_reset();
      m_prio = 1'b0; m_lock_act = 1'b0; m_lock_own = 1'b0; m_to = 1'b0;
   endtask

   // One command from IDLE back to IDLE; aw/dw are address/data wait states.
   task automatic txn(input logic [1:0] vld, input tcmd_t c0, input tcmd_t c1,
                      input int aw, input int dw, input bit err, input logic [31:0] rdata);
      int         w;
      tcmd_t      c;
      bit         lg;
      logic [1:0] oh;
      drive_cmds(vld, c0, c1);
      HREADY = 1'b1;
      HRESP  = 1'b0;
      #1;
      w = pick(vld);
      if (w < 0) begin
         check("ready_blocked_by_lock", CMD_READY, 0);
         tick();
         return;
      end
      oh = (w == 1) ? 2'b10 : 2'b01;
      check("cmd_ready", CMD_READY, oh);
      check("busy_idle", BUSY, 0);
      if (chk_fp) check("fixed_prio_ready", fp_CMD_READY, 2'b01);
      grant_log.push_back(CMD_READY == 2'b10 ? 1 : (CMD_READY == 2'b01 ? 0 : -1));
      c  = (w == 1) ? c1 : c0;
      lg = legal(c);
      m_prio     = (w == 0);
      m_lock_act = c.lock;
      m_lock_own = (w == 1);
      tick();

      if (!lg) begin
         check("illegal_rsp_valid", RSP_VALID, oh);
         check("illegal_rsp_err", RSP_ERR, 1);
         check("illegal_no_nonseq", HTRANS, 0);
         tick();
         check("illegal_rsp_done", RSP_VALID, 0);
         return;
      end

      check("addr_htrans", HTRANS, 2'b10);
      check("addr_haddr", HADDR, c.addr);
      check("addr_hwrite", HWRITE, c.write);
      check("addr_hsize", HSIZE, c.size);
      check("addr_hmastlock", HMASTLOCK, c.lock);
      check("addr_hburst", HBURST, 0);
      check("addr_hprot", HPROT, 4'b0011);
      check("addr_rsp_quiet", RSP_VALID, 0);
      for (int k = 0; k < aw; k++) begin
         HREADY = 1'b0;
         tick();
         check("addr_wait_htrans", HTRANS, 2'b10);
      end
      HREADY = 1'b1;
      tick();

      for (int k = 0; k <= dw; k++) begin
         check("data_htrans", HTRANS, 0);
         check("data_hmastlock", HMASTLOCK, 0);
         check("data_hwdata", HWDATA, c.wdata);
         check("data_rsp_quiet", RSP_VALID, 0);
         check("data_timeout", TIMEOUT, (m_to || k >= int'(TO)) ? 1 : 0);
         if (k < dw) begin
            HREADY = 1'b0;
            HRESP  = (err && k == dw - 1) ? 1'b1 : 1'($urandom_range(0, 1));
         end else begin
            HREADY = 1'b1;
            HRESP  = err;
            HRDATA = rdata;
         end
         tick();
      end
      if (dw >= int'(TO)) m_to = 1'b1;

      check("resp_valid", RSP_VALID, oh);
      check("resp_rdata", RSP_RDATA, c.write ? 32'd0 : rdata);
      check("resp_err", RSP_ERR, err);
      check("resp_timeout", TIMEOUT, m_to);
      check("resp_busy", BUSY, 1);
      HREADY = 1'b1;
      HRESP  = 1'b0;
      tick();
      check("resp_one_cycle", RSP_VALID, 0);
      check("idle_busy", BUSY, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tcmd_t c0, c1, rd0;
      int    rr_exp[4];
      logic [1:0] vld;
      int    aw, dw;
      bit    err;

      model_reset();
      chk_fp = 1'b0;
      HRESET = 1'b1;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
      rd0 = mk(1'b0, 1'b0, 3'd2, 32'h0000_0010, 32'h0);
      drive_cmds(2'b11, rd0, rd0);
      tick();
      tick();

      // Reset state (inputs still requesting)
      check("rst_cmd_ready", CMD_READY, 0);
      check("rst_rsp_valid", RSP_VALID, 0);
      check("rst_rsp_err", RSP_ERR, 0);
      check("rst_rsp_rdata", RSP_RDATA, 0);
      check("rst_haddr", HADDR, 0);
      check("rst_hwdata", HWDATA, 0);
      check("rst_hwrite", HWRITE, 0);
      check("rst_hmastlock", HMASTLOCK, 0);
      check("rst_htrans", HTRANS, 0);
      check("rst_hsize", HSIZE, 0);
      check("rst_hburst", HBURST, 0);
      check("rst_hprot", HPROT, 4'b0011);
      check("rst_busy", BUSY, 0);
      check("rst_timeout", TIMEOUT, 0);
      CMD_VALID = 2'b00;
      HRESET = 1'b0;

      // Round-robin vs fixed priority, both requesters always valid
      chk_fp = 1'b1;
      grant_log.delete();
      for (int i = 0; i < 4; i++) txn(2'b11, rd0, rd0, 0, 0, 1'b0, $urandom);
      rr_exp = '{0, 1, 0, 1};
      for (int i = 0; i < 4; i++) check($sformatf("rr_order_%0d", i), grant_log[i], rr_exp[i]);
      chk_fp = 1'b0;

      // Single requester read
      txn(2'b01, rd0, rd0, 0, 0, 1'b0, 32'hCAFE_F00D);

      // Lock: requester 1 keeps the bus across two commands
      grant_log.delete();
      c1 = mk(1'b1, 1'b1, 3'd2, 32'h0000_1000, 32'h1111_2222);
      txn(2'b10, rd0, c1, 0, 0, 1'b0, 32'h0);
      c1 = mk(1'b0, 1'b0, 3'd1, 32'h0000_1002, 32'h0);
      txn(2'b11, rd0, c1, 1, 1, 1'b0, 32'h5A5A_0001);
      txn(2'b11, rd0, c1, 0, 0, 1'b0, 32'h0BAD_BEEF);
      check("lock_order_0", grant_log[0], 1);
      check("lock_order_1", grant_log[1], 1);
      check("lock_order_2", grant_log[2], 0);

      // Illegal commands: oversize and misaligned
      c0 = mk(1'b0, 1'b0, 3'b011, 32'h0000_0020, 32'h0);
      txn(2'b01, c0, rd0, 0, 0, 1'b0, 32'h0);
      c1 = mk(1'b1, 1'b0, 3'd2, 32'h0000_0042, 32'h0);
      txn(2'b10, rd0, c1, 0, 0, 1'b0, 32'h0);

      // Error response after a long wait, timeout at 4 wait states
      check("timeout_before", TIMEOUT, 0);
      c0 = mk(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF);
      txn(2'b01, c0, rd0, 0, 5, 1'b1, 32'h0);
      check("timeout_sticky", TIMEOUT, 1);

      // Randomized commands
      for (int n = 0; n < 40; n++) begin
         c0  = rand_cmd();
         c1  = rand_cmd();
         vld = 2'($urandom_range(1, 3));
         aw  = $urandom_range(0, 2);
         dw  = $urandom_range(0, 6);
         err = ($urandom_range(0, 3) == 0);
         if (err && dw == 0) dw = 1;
         txn(vld, c0, c1, aw, dw, err, $urandom);
      end

      // Reset in the data phase discards the transfer
      m_lock_act = 1'b0;
      HRESET = 1'b1;
      tick();
      HRESET = 1'b0;
      model_reset();
      drive_cmds(2'b01, rd0, rd0);
      #1;
      check("mid_rst_accept", CMD_READY, 2'b01);
      tick();
      HREADY = 1'b1;
      tick();
      HREADY = 1'b0;
      tick();
      check("mid_rst_in_data", BUSY, 1);
      HRESET = 1'b1;
      CMD_VALID = 2'b00;
      tick();
      check("mid_rst_rsp_valid", RSP_VALID, 0);
      check("mid_rst_htrans", HTRANS, 0);
      check("mid_rst_busy", BUSY, 0);
      HRESET = 1'b0;
      HREADY = 1'b1;
      tick();
      check("mid_rst_no_late_rsp", RSP_VALID, 0);
      check("mid_rst_idle", BUSY, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
